// File: rtl/fb_arb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// fb_arb_pkg -- shared types and frame defaults for the framebuffer arbiter. Rev 1.0
//------------------------------------------------------------------------------
package fb_arb_pkg;

  localparam int unsigned c_FRAME_WORDS = 307200;
  localparam int unsigned c_FB1_BASE    = 307200;

  typedef enum logic [1:0] {NONE, DISP, WR} owner_t;
  typedef enum logic {IDLE, ARMED} swap_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// fb_swap_ctrl -- vsync-aligned front/back buffer swap controller. Rev 1.0
//------------------------------------------------------------------------------
module fb_swap_ctrl
  import fb_arb_pkg::*;
#(
  parameter logic VS_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic v_sync_i,
  input  logic swap_req_i,
  output logic front_buf_o,
  output logic swap_pending_o
);

  swap_state_t state_q, state_d;
  logic        front_q, front_d;
  logic        vs_q;
  logic        w_vs_edge;

  // History resets to the active level so a sync already active out of reset is not an edge.
  assign w_vs_edge = (v_sync_i == VS_POL) && (vs_q != VS_POL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      front_q <= 1'b0;
      vs_q    <= VS_POL;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      vs_q    <= v_sync_i;
    end
  end

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    case (state_q)
      IDLE: begin
        if (swap_req_i) begin
          if (w_vs_edge) front_d = ~front_q;
          else           state_d = ARMED;
        end
      end
      ARMED: begin
        if (w_vs_edge) begin
          front_d = ~front_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign front_buf_o    = front_q;
  assign swap_pending_o = (state_q == ARMED);

endmodule
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// fb_port_arbiter -- shares one framebuffer port between display reads and pixel writes. Rev 1.0
//------------------------------------------------------------------------------
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FRAME_WORDS  = c_FRAME_WORDS,
  parameter int unsigned FB1_BASE     = c_FB1_BASE,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic        VS_POL       = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_sync_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_gnt_o,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_rvalid_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  output logic              wr_drop_o,
  input  logic              swap_req_i,
  output logic              swap_pending_o,
  output logic              front_buf_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned              c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0]    c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0]        c_FRAME      = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0]        c_FB1        = ADDR_W'(FB1_BASE);

  owner_t                  w_owner;
  logic                    w_disp_ok, w_wr_ok;
  logic [ADDR_W-1:0]       w_disp_phys, w_wr_phys;
  logic [c_STARVE_W-1:0]   starve_q, starve_d;
  logic                    mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    rd1_vld_q, rd1_ok_q, rd2_vld_q, rd2_ok_q;
  logic                    wr_drop_q;

  fb_swap_ctrl #(.VS_POL(VS_POL)) u_swap (
    .clk            (clk),
    .rst            (rst),
    .v_sync_i       (v_sync_i),
    .swap_req_i     (swap_req_i),
    .front_buf_o    (front_buf_o),
    .swap_pending_o (swap_pending_o)
  );

  // Display wins unless the writer has been starved for the full limit.
  always_comb begin
    w_owner = NONE;
    if (!rst) begin
      if (wr_req_i && (!disp_req_i || starve_q == c_STARVE_MAX)) w_owner = WR;
      else if (disp_req_i)                                         w_owner = DISP;
    end
  end

  assign disp_gnt_o = (w_owner == DISP);
  assign wr_gnt_o   = (w_owner == WR);

  always_comb begin
    starve_d = '0;
    if (wr_req_i && !wr_gnt_o)
      starve_d = (starve_q == c_STARVE_MAX) ? starve_q : starve_q + c_STARVE_W'(1);
  end

  assign w_disp_ok   = (disp_addr_i < c_FRAME);
  assign w_wr_ok     = (wr_addr_i < c_FRAME);
  assign w_disp_phys = (front_buf_o ? c_FB1 : {ADDR_W{1'b0}}) + disp_addr_i;
  assign w_wr_phys   = (front_buf_o ? {ADDR_W{1'b0}} : c_FB1) + wr_addr_i;

  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (w_owner)
      DISP: begin
        mem_en_d   = w_disp_ok;
        mem_addr_d = w_disp_ok ? w_disp_phys : '0;
      end
      WR: begin
        mem_en_d    = w_wr_ok;
        mem_we_d    = w_wr_ok;
        mem_addr_d  = w_wr_ok ? w_wr_phys : '0;
        mem_wdata_d = w_wr_ok ? wr_data_i : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd1_vld_q   <= 1'b0;
      rd1_ok_q    <= 1'b0;
      rd2_vld_q   <= 1'b0;
      rd2_ok_q    <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd1_vld_q   <= disp_gnt_o;
      rd1_ok_q    <= disp_gnt_o && w_disp_ok;
      rd2_vld_q   <= rd1_vld_q;
      rd2_ok_q    <= rd1_ok_q;
      wr_drop_q   <= wr_drop_q | (wr_gnt_o & ~w_wr_ok);
    end
  end

  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign disp_rvalid_o = rd2_vld_q;
  assign disp_rdata_o  = rd2_ok_q ? mem_rdata_i : '0;
  assign wr_drop_o     = wr_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_fb_port_arbiter -- self-checking bench for fb_port_arbiter. Rev 1.0
//------------------------------------------------------------------------------
module tb_fb_port_arbiter;

  localparam int FRAME  = 307200;
  localparam int FB1    = 307200;
  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_sync = 1'b1, disp_req = 1'b0, wr_req = 1'b0, swap_req = 1'b0;
  logic [19:0] disp_addr = '0, wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        disp_gnt, disp_rvalid, wr_gnt, wr_drop, swap_pending, front_buf, mem_en, mem_we;
  logic [15:0] disp_rdata, mem_wdata;
  logic [19:0] mem_addr;
  logic [15:0] mem_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .ADDR_W(20), .DATA_W(16), .FRAME_WORDS(FRAME), .FB1_BASE(FB1),
    .STARVE_LIMIT(STARVE), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .v_sync_i(v_sync),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr), .disp_gnt_o(disp_gnt),
    .disp_rdata_o(disp_rdata), .disp_rvalid_o(disp_rvalid),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
    .wr_drop_o(wr_drop), .swap_req_i(swap_req), .swap_pending_o(swap_pending),
    .front_buf_o(front_buf), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Framebuffer memory with one-cycle read latency.
  logic [15:0] fbmem [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) fbmem[int'(mem_addr)] = mem_wdata;
      else        mem_rdata <= fbmem.exists(int'(mem_addr)) ? fbmem[int'(mem_addr)] : 16'h0;
    end
  end

  // Reference model: grant order defines memory order, reads return after two cycles.
  typedef struct { int due; logic [15:0] data; } rd_t;
  rd_t         rdq[$];
  logic [15:0] ref_mem [int];
  logic        m_front = 0, m_pend = 0, m_prev_vs = 0, m_drop = 0;
  int          m_starve = 0, cyc = 0;
  logic        e_dgnt = 0, e_wgnt = 0;
  logic        n_en = 0, n_we = 0, e_en = 0, e_we = 0;
  logic [19:0] n_addr = '0, e_addr = '0;
  logic [15:0] n_wdata = '0, e_wdata = '0, e_rdata = '0;
  logic        e_rvalid = 0, e_front = 0, e_pend = 0, e_drop = 0;

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  function automatic logic [19:0] rnd_off();
    if ($urandom % 8 == 0) return 20'(FRAME + int'($urandom % 1000));
    return 20'($urandom % 16);
  endfunction

  task automatic drive(input logic dr, input logic [19:0] da, input logic wr, input logic [19:0] wa,
                       input logic [15:0] wd, input logic sr, input logic vs);
    int   a;
    logic edge_s;
    rd_t  r;
    disp_req = dr; disp_addr = da; wr_req = wr; wr_addr = wa; wr_data = wd;
    swap_req = sr; v_sync = vs;
    e_wgnt = !rst && wr && (!dr || m_starve == STARVE);
    e_dgnt = !rst && dr && !e_wgnt;
    n_en = 0; n_we = 0; n_addr = '0; n_wdata = '0;
    if (!rst) begin
      if (e_dgnt) begin
        a = (m_front ? FB1 : 0) + int'(da);
        r.due = cyc + 2;
        r.data = 16'h0;
        if (int'(da) < FRAME) begin
          n_en = 1; n_addr = a[19:0]; r.data = ref_rd(a);
        end
        rdq.push_back(r);
      end
      if (e_wgnt) begin
        a = (m_front ? 0 : FB1) + int'(wa);
        if (int'(wa) < FRAME) begin
          n_en = 1; n_we = 1; n_addr = a[19:0]; n_wdata = wd; ref_mem[a] = wd;
        end else m_drop = 1;
      end
      m_starve = (wr && !e_wgnt) ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
      edge_s = (vs == 1'b0) && (m_prev_vs != 1'b0);
      if (edge_s && (m_pend || sr)) begin m_front = !m_front; m_pend = 0; end
      else if (sr) m_pend = 1;
      m_prev_vs = vs;
    end
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_front = 0; m_pend = 0; m_prev_vs = 0; m_starve = 0; m_drop = 0;
      rdq.delete();
      n_en = 0; n_we = 0; n_addr = '0; n_wdata = '0;
    end
    e_en = n_en; e_we = n_we; e_addr = n_addr; e_wdata = n_wdata;
    e_front = m_front; e_pend = m_pend; e_drop = m_drop;
    e_rvalid = 0; e_rdata = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      e_rvalid = 1; e_rdata = rdq[0].data;
      void'(rdq.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    drive(1, 20'd3, 1, 20'd4, 16'h55, 1, 1);
    n_chk++; if ({disp_gnt, wr_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", {disp_gnt, wr_gnt}); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    advance();
    n_chk++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_mem got en=%b we=%b addr=%0d wdata=%h exp all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    n_chk++; if ({disp_rvalid, wr_drop, swap_pending, front_buf} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got rv/drop/pend/front=%b exp=0000", {disp_rvalid, wr_drop, swap_pending, front_buf}); end
    rst = 0;
  endtask

  task automatic test_swap();
    drive(0, 0, 0, 0, 0, 0, 1); advance();
    drive(0, 0, 0, 0, 0, 1, 1); advance();
    n_chk++; if ({swap_pending, front_buf} !== 2'b10) begin n_fail++; $display("FAIL swap_arm got pend/front=%b exp=10", {swap_pending, front_buf}); end
    drive(0, 0, 0, 0, 0, 1, 1); advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1); advance();
      n_chk++; if ({swap_pending, front_buf} !== 2'b10) begin n_fail++; $display("FAIL swap_wait got pend/front=%b exp=10", {swap_pending, front_buf}); end
    end
    drive(0, 0, 0, 0, 0, 0, 0); advance();
    n_chk++; if ({swap_pending, front_buf} !== 2'b01) begin n_fail++; $display("FAIL swap_toggle got pend/front=%b exp=01", {swap_pending, front_buf}); end
    drive(0, 0, 0, 0, 0, 0, 1); advance();
    drive(0, 0, 0, 0, 0, 0, 0); advance();
    n_chk++; if ({swap_pending, front_buf} !== 2'b01) begin n_fail++; $display("FAIL swap_single got pend/front=%b exp=01", {swap_pending, front_buf}); end
  endtask

  task automatic test_read_stream();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 20'(i), 16'(16'hA0 + i), 0, 0);
      n_chk++; if (wr_gnt !== 1'b1) begin n_fail++; $display("FAIL stream_wr_gnt got=%b exp=1", wr_gnt); end
      advance();
    end
    drive(0, 0, 0, 0, 0, 1, 1); advance();
    drive(0, 0, 0, 0, 0, 0, 0); advance();
    n_chk++; if (front_buf !== 1'b0) begin n_fail++; $display("FAIL stream_front got=%b exp=0", front_buf); end
    for (int k = 0; k < 6; k++) begin
      drive(k < 4, 20'(k), 0, 0, 0, 0, 0);
      advance();
      if (k < 4) begin
        n_chk++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 20'(k)}) begin n_fail++; $display("FAIL stream_addr k=%0d got en=%b we=%b addr=%0d exp 1/0/%0d", k, mem_en, mem_we, mem_addr, k); end
      end
      n_chk++; if (disp_rvalid !== (k >= 1 && k <= 4)) begin n_fail++; $display("FAIL stream_rvalid k=%0d got=%b exp=%b", k, disp_rvalid, (k >= 1 && k <= 4)); end
      if (k >= 1 && k <= 4) begin
        n_chk++; if (disp_rdata !== 16'(16'hA0 + k - 1)) begin n_fail++; $display("FAIL stream_rdata k=%0d got=%h exp=%h", k, disp_rdata, 16'(16'hA0 + k - 1)); end
      end
    end
  endtask

  task automatic test_starve();
    logic exp_w;
    for (int c = 1; c <= 20; c++) begin
      drive(1, 20'd7, 1, 20'd9, 16'hBEEF, 0, 0);
      exp_w = (c == 9 || c == 18);
      n_chk++; if ({disp_gnt, wr_gnt} !== {!exp_w, exp_w}) begin n_fail++; $display("FAIL starve_gnt cycle=%0d got d/w=%b%b exp=%b%b", c, disp_gnt, wr_gnt, !exp_w, exp_w); end
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0); advance();
  endtask

  task automatic test_addr_map();
    drive(0, 0, 1, 20'd5, 16'h1234, 0, 0); advance();
    n_chk++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 20'd307205, 16'h1234}) begin n_fail++; $display("FAIL map_wr got en=%b we=%b addr=%0d wdata=%h exp 1/1/307205/1234", mem_en, mem_we, mem_addr, mem_wdata); end
    drive(1, 20'd5, 0, 0, 0, 0, 0); advance();
    n_chk++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 20'd5}) begin n_fail++; $display("FAIL map_rd got en=%b we=%b addr=%0d exp 1/0/5", mem_en, mem_we, mem_addr); end
    drive(0, 0, 0, 0, 0, 0, 0); advance();
  endtask

  task automatic test_oob();
    drive(0, 0, 1, 20'd307200, 16'h7777, 0, 0);
    n_chk++; if (wr_gnt !== 1'b1) begin n_fail++; $display("FAIL oob_wr_gnt got=%b exp=1", wr_gnt); end
    advance();
    n_chk++; if ({mem_en, wr_drop} !== 2'b01) begin n_fail++; $display("FAIL oob_wr got en/drop=%b exp=01", {mem_en, wr_drop}); end
    drive(1, 20'd0, 0, 0, 0, 0, 0); advance();
    drive(1, 20'd400000, 0, 0, 0, 0, 0);
    n_chk++; if (disp_gnt !== 1'b1) begin n_fail++; $display("FAIL oob_rd_gnt got=%b exp=1", disp_gnt); end
    advance();
    n_chk++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL oob_rd_en got=%b exp=0", mem_en); end
    drive(0, 0, 0, 0, 0, 0, 0); advance();
    n_chk++; if ({disp_rvalid, disp_rdata} !== {1'b1, 16'h0}) begin n_fail++; $display("FAIL oob_rdata got rv=%b data=%h exp rv=1 data=0000", disp_rvalid, disp_rdata); end
    drive(0, 0, 0, 0, 0, 0, 0); advance();
    n_chk++; if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL oob_sticky got=%b exp=1", wr_drop); end
  endtask

  task automatic test_reset_inflight();
    drive(0, 0, 0, 0, 0, 0, 1); advance();
    drive(0, 0, 0, 0, 0, 1, 0); advance();
    n_chk++; if ({swap_pending, front_buf} !== 2'b01) begin n_fail++; $display("FAIL same_cycle_swap got pend/front=%b exp=01", {swap_pending, front_buf}); end
    drive(0, 0, 0, 0, 0, 1, 0); advance();
    drive(1, 20'd1, 0, 0, 0, 0, 0); advance();
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0); advance();
    rst = 0;
    n_chk++; if ({disp_rvalid, swap_pending, front_buf} !== 3'b000) begin n_fail++; $display("FAIL rst_inflight got rv/pend/front=%b exp=000", {disp_rvalid, swap_pending, front_buf}); end
    drive(0, 0, 0, 0, 0, 1, 0); advance();
    n_chk++; if ({disp_rvalid, swap_pending, front_buf} !== 3'b010) begin n_fail++; $display("FAIL rst_vsync got rv/pend/front=%b exp=010", {disp_rvalid, swap_pending, front_buf}); end
  endtask

  task automatic test_random();
    logic dr, wr, vs, sr;
    logic [19:0] da, wa;
    logic [15:0] wd;
    dr = 0; wr = 0; vs = v_sync; da = '0; wa = '0; wd = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!dr && ($urandom % 4 != 0)) begin dr = 1; da = rnd_off(); end
      if (!wr && ($urandom % 3 != 0)) begin wr = 1; wa = rnd_off(); wd = 16'($urandom); end
      sr = ($urandom % 10 == 0);
      if ($urandom % 6 == 0) vs = ~vs;
      drive(dr, da, wr, wa, wd, sr, vs);
      n_chk++; if ({disp_gnt, wr_gnt} !== {e_dgnt, e_wgnt}) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got d/w=%b%b exp=%b%b", cyc, disp_gnt, wr_gnt, e_dgnt, e_wgnt); end
      if (e_dgnt) dr = 0;
      if (e_wgnt) wr = 0;
      advance();
      n_chk++; if (mem_en !== e_en) begin n_fail++; $display("FAIL rnd_mem_en cyc=%0d got=%b exp=%b", cyc, mem_en, e_en); end
      if (e_en) begin
        n_chk++; if ({mem_we, mem_addr} !== {e_we, e_addr}) begin n_fail++; $display("FAIL rnd_mem_cmd cyc=%0d got we=%b addr=%0d exp we=%b addr=%0d", cyc, mem_we, mem_addr, e_we, e_addr); end
      end
      if (e_en && e_we) begin
        n_chk++; if (mem_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, e_wdata); end
      end
      n_chk++; if (disp_rvalid !== e_rvalid) begin n_fail++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, disp_rvalid, e_rvalid); end
      if (e_rvalid) begin
        n_chk++; if (disp_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, disp_rdata, e_rdata); end
      end
      n_chk++; if ({front_buf, swap_pending, wr_drop} !== {e_front, e_pend, e_drop}) begin n_fail++; $display("FAIL rnd_flags cyc=%0d got front/pend/drop=%b exp=%b", cyc, {front_buf, swap_pending, wr_drop}, {e_front, e_pend, e_drop}); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_swap();
    test_read_stream();
    test_starve();
    test_addr_map();
    test_oob();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
